sprite_anim_ctrl: RTL and testbench
===================================

Name: sprite_anim_ctrl

Overview:
- Sequencer and address generator for a multi-frame palettized sprite ROM, e.g. the knight fall animation: NUM_FRAMES frames of SPR_W x SPR_H pixels stored back to back.
- Steps the animation frame on video-frame boundaries.
- Latches the sprite screen position once per video frame.
- Converts DrawX/DrawY into a ROM address.
- Returns a registered palette index with a hit/opaque flag to the pixel mux ahead of the palette lookup.

Parameters:
SPR_W, 50, sprite width in pixels
SPR_H, 64, sprite height in pixels
NUM_FRAMES, 6, animation frames stored in ROM (frame 0 at address 0)
FRAME_TICKS, 4, video frames each animation frame is shown (>=1)
ADDR_W, 15, ROM address width (must hold NUM_FRAMES*SPR_W*SPR_H-1)
IDX_W, 3, palette index width
TRANSPARENT, 0, palette index treated as transparent

Ports:
vga_clk  in  1  pixel clock; all logic is on its rising edge
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
trigger  in  1  request to start or restart the animation
loop_en  in  1  1 = wrap to frame 0 after the last frame; 0 = hold the last frame
pos_x  in  10  sprite top-left X, sampled at frame_start
pos_y  in  10  sprite top-left Y, sampled at frame_start
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
blank  in  1  1 = active video (same sense as the VGA controller)
rom_address  out  ADDR_W  address to the synchronous sprite ROM
rom_q  in  IDX_W  ROM data, valid one vga_clk after rom_address
pixel_valid  out  1  sprite pixel is opaque, inside the sprite box and in active video
pixel_index  out  IDX_W  palette index for the pixel
frame_idx  out  3  current animation frame
busy  out  1  high in PLAY
done  out  1  one-cycle pulse when a non-looping animation reaches its last frame

Behaviour:
- Reset (async assert, sync release): state=IDLE; armed, frame_idx, tick_cnt, latched pos, rom_address, pixel_valid, pixel_index, busy and done all 0. Asserting reset mid-animation aborts at once.
- States IDLE, PLAY, HOLD.
- IDLE:
  - frame_idx=0.
  - trigger sets armed.
  - frame_start with armed or trigger -> PLAY, tick_cnt=0, armed cleared.
  - trigger coincident with frame_start enters PLAY at that frame_start.
- PLAY:
  - busy=1; trigger ignored.
  - On each frame_start: if tick_cnt<FRAME_TICKS-1, tick_cnt++.
  - Otherwise tick_cnt=0 and:
    - frame_idx<NUM_FRAMES-1: frame_idx++.
    - frame_idx==NUM_FRAMES-1 and loop_en=1: frame_idx=0.
    - frame_idx==NUM_FRAMES-1 and loop_en=0: -> HOLD, done=1 for that cycle.
- HOLD:
  - frame_idx stays NUM_FRAMES-1.
  - trigger sets armed.
  - Next frame_start with armed or trigger -> PLAY with frame_idx=0, tick_cnt=0.
- frame_idx changes and pos_x/pos_y latches happen only on frame_start cycles, so nothing changes mid-scan (no tearing).
- Pixel pipeline, stage 1 (registered on the DrawX/DrawY cycle):
  - hit = DrawX>=px && DrawX-px<SPR_W && DrawY>=py && DrawY-py<SPR_H, using 10-bit unsigned compares on latched px/py.
  - rom_address = frame_idx*SPR_W*SPR_H + (DrawY-py)*SPR_W + (DrawX-px), computed in ADDR_W bits, constant multipliers only.
  - When hit=0, rom_address=0.
  - hit_d and blank_d are registered alongside rom_address.
- Stage 2: pixel_index<=rom_q; pixel_valid<=hit_d & blank_d & (rom_q!=TRANSPARENT).
- Latency DrawX/DrawY -> pixel_valid/pixel_index is exactly 2 cycles. The caller delays DrawX/blank to match.
- Sprite boxes extending past X=639 or Y=479 are clipped naturally. No wrap-around: compares are unsigned and never underflow.
- Simultaneous done and trigger in the same cycle: trigger is captured in armed; the restart takes effect at the next frame_start.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0, state IDLE. Assert reset_n=0 mid-PLAY at frame_idx=3 -> frame_idx=0, busy=0 asynchronously.
- Sequencing (NUM_FRAMES=6, FRAME_TICKS=4, loop_en=0): trigger, then 24 frame_start pulses -> frame_idx steps 0..5, one step every 4 pulses; done pulses once on pulse 24 after entering PLAY; frame_idx holds at 5; busy drops.
- Looping (loop_en=1): 30 frame_start pulses -> frame_idx sequence 0,1,2,3,4,5,0,..., busy stays 1, no done.
- Addressing: pos=(100,200), frame_idx=2, DrawX=149, DrawY=263 -> rom_address=6400+63*50+49=9599 one cycle later. DrawX=150 -> hit=0, rom_address=0.
- Transparency/blank: rom_q=0 inside the box -> pixel_valid=0. rom_q=5 with blank=0 -> pixel_valid=0. rom_q=5 with blank=1 -> pixel_valid=1, pixel_index=5, 2 cycles after DrawX.
- Tear-free: change pos_x mid-frame -> rom_address uses the old position until the next frame_start, then the new one. Trigger coincident with frame_start in IDLE -> PLAY the same cycle.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_anim_ctrl
//
// Sequencer and address generator for a multi-frame palettized sprite stored
// in a synchronous ROM (NUM_FRAMES frames of SPR_W x SPR_H pixels, frame 0 at
// address 0, frames back to back).  The animation frame advances only on
// video-frame boundaries and the sprite position is latched at the same
// moment, so a scan never sees a half-updated sprite.
//
// Ports
//   vga_clk      in   pixel clock, all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse at the start of vertical blank
//   trigger      in   request to start / restart the animation
//   loop_en      in   1 = wrap to frame 0 after last frame, 0 = hold last
//   pos_x/pos_y  in   sprite top-left corner, sampled at frame_start
//   DrawX/DrawY  in   current pixel coordinates
//   blank        in   1 = active video
//   rom_address  out  address to the sprite ROM (0 outside the sprite box)
//   rom_q        in   ROM data for the previous cycle's rom_address
//   pixel_valid  out  opaque sprite pixel inside the box in active video
//   pixel_index  out  palette index for the pixel
//   frame_idx    out  current animation frame
//   busy         out  high while the animation is playing
//   done         out  one-cycle pulse when a non-looping run finishes
//
// Pixel latency DrawX/DrawY -> pixel_valid/pixel_index is two cycles.
// ---------------------------------------------------------------------------
module sprite_anim_ctrl #(
    parameter int SPR_W       = 50,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 6,
    parameter int FRAME_TICKS = 4,
    parameter int ADDR_W      = 15,
    parameter int IDX_W       = 3,
    parameter int TRANSPARENT = 0
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              trigger,
    input  logic              loop_en,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              pixel_valid,
    output logic [IDX_W-1:0]  pixel_index,
    output logic [2:0]        frame_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FRAME_PIX = SPR_W * SPR_H;

    localparam logic [2:0]        LAST_FRAME = 3'(NUM_FRAMES - 1);
    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(FRAME_TICKS - 1);

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic              r_armed;
    logic [2:0]        r_frame_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_done;
    logic [9:0]        r_px;
    logic [9:0]        r_py;

    logic [1:0]        w_state_nxt;
    logic              w_armed_nxt;
    logic [2:0]        w_frame_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              w_done_nxt;

    // A start request is a trigger either seen earlier (armed) or arriving
    // in the very frame_start cycle itself.
    logic w_start;
    assign w_start = frame_start && (r_armed || trigger);

    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_frame_nxt = r_frame_idx;
        w_tick_nxt  = r_tick_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_frame_nxt = 3'd0;
                if (w_start) begin
                    w_state_nxt = S_PLAY;
                    w_tick_nxt  = '0;
                    w_armed_nxt = 1'b0;
                end else if (trigger) begin
                    w_armed_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                // trigger is deliberately ignored while playing
                if (frame_start) begin
                    if (r_tick_cnt < LAST_TICK) begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end else begin
                        w_tick_nxt = '0;
                        if (r_frame_idx < LAST_FRAME) begin
                            w_frame_nxt = r_frame_idx + 3'd1;
                        end else if (loop_en) begin
                            w_frame_nxt = 3'd0;
                        end else begin
                            w_state_nxt = S_HOLD;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                w_frame_nxt = LAST_FRAME;
                if (w_start) begin
                    w_state_nxt = S_PLAY;
                    w_frame_nxt = 3'd0;
                    w_tick_nxt  = '0;
                    w_armed_nxt = 1'b0;
                end else if (trigger) begin
                    w_armed_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_armed_nxt = 1'b0;
                w_frame_nxt = 3'd0;
                w_tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_frame_idx <= 3'd0;
            r_tick_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_armed     <= w_armed_nxt;
            r_frame_idx <= w_frame_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Position is captured only at frame_start so a mid-scan move takes
    // effect on the next video frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px <= 10'd0;
            r_py <= 10'd0;
        end else if (frame_start) begin
            r_px <= pos_x;
            r_py <= pos_y;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p0 -> p1: box test and ROM address
    // -----------------------------------------------------------------------
    logic [9:0]        w_dx_p0;
    logic [9:0]        w_dy_p0;
    logic              w_hit_p0;
    logic [ADDR_W-1:0] w_addr_p0;

    assign w_dx_p0 = DrawX - r_px;
    assign w_dy_p0 = DrawY - r_py;

    // The >= guards make the subtraction safe: an underflowed offset is
    // never accepted, so boxes near the screen edge clip without wrapping.
    assign w_hit_p0 = (DrawX >= r_px) && (w_dx_p0 < 10'(SPR_W)) &&
                      (DrawY >= r_py) && (w_dy_p0 < 10'(SPR_H));

    assign w_addr_p0 = ADDR_W'(r_frame_idx) * ADDR_W'(FRAME_PIX) +
                       ADDR_W'(w_dy_p0)     * ADDR_W'(SPR_W) +
                       ADDR_W'(w_dx_p0);

    logic [ADDR_W-1:0] r_rom_address_p1;
    logic              r_hit_p1;
    logic              r_blank_p1;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_address_p1 <= '0;
            r_hit_p1         <= 1'b0;
            r_blank_p1       <= 1'b0;
        end else begin
            r_rom_address_p1 <= w_hit_p0 ? w_addr_p0 : '0;
            r_hit_p1         <= w_hit_p0;
            r_blank_p1       <= blank;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1 -> p2: ROM data qualified by box, blank and transparency
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] r_pixel_index_p2;
    logic             r_pixel_valid_p2;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_index_p2 <= '0;
            r_pixel_valid_p2 <= 1'b0;
        end else begin
            r_pixel_index_p2 <= rom_q;
            r_pixel_valid_p2 <= r_hit_p1 & r_blank_p1 &
                                (rom_q != IDX_W'(TRANSPARENT));
        end
    end

    assign rom_address = r_rom_address_p1;
    assign pixel_index = r_pixel_index_p2;
    assign pixel_valid = r_pixel_valid_p2;
    assign frame_idx   = r_frame_idx;
    assign busy        = (r_state == S_PLAY);
    assign done        = r_done;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_ctrl
//
// Directed bench for sprite_anim_ctrl with default parameters.  Sequencing
// is exercised with hand-written pulse sequences; the pixel pipeline is
// driven from a per-cycle table of inputs and hand-computed outputs.
// ---------------------------------------------------------------------------
module tb_sprite_anim_ctrl;

    logic        vga_clk;
    logic        reset_n;
    logic        frame_start;
    logic        trigger;
    logic        loop_en;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic [14:0] rom_address;
    logic [2:0]  rom_q;
    logic        pixel_valid;
    logic [2:0]  pixel_index;
    logic [2:0]  frame_idx;
    logic        busy;
    logic        done;

    sprite_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .trigger     (trigger),
        .loop_en     (loop_en),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_idx   (frame_idx),
        .busy        (busy),
        .done        (done)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_vec;
    int n_err;

    typedef struct {
        logic        fs;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        blk;
        logic [2:0]  q;
        logic [14:0] e_addr;
        logic        e_pv;
        logic [2:0]  e_pi;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // advance one clock; return 1 time unit after the edge
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rom_address"}, 32'(rom_address), 0);
        chk({tag, " pixel_valid"}, 32'(pixel_valid), 0);
        chk({tag, " pixel_index"}, 32'(pixel_index), 0);
        chk({tag, " frame_idx"},   32'(frame_idx),   0);
        chk({tag, " busy"},        32'(busy),        0);
        chk({tag, " done"},        32'(done),        0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        // ---------------- reset with random inputs ----------------
        reset_n     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            frame_start = 1'($urandom);
            trigger     = 1'($urandom);
            loop_en     = 1'($urandom);
            pos_x       = 10'($urandom);
            pos_y       = 10'($urandom);
            DrawX       = 10'($urandom);
            DrawY       = 10'($urandom);
            blank       = 1'($urandom);
            rom_q       = 3'($urandom);
            step();
            chk_all_zero($sformatf("reset[%0d]", i));
        end

        frame_start = 1'b0;
        trigger     = 1'b0;
        loop_en     = 1'b0;
        pos_x       = 10'd100;
        pos_y       = 10'd200;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        blank       = 1'b0;
        rom_q       = 3'd0;
        #3 reset_n  = 1'b1;
        step();

        // frame_start without any trigger stays idle
        pulse();
        chk("idle fs-only busy", 32'(busy), 0);
        // trigger alone only arms
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("idle arm busy", 32'(busy), 0);
        step();
        pulse();
        chk("armed start busy", 32'(busy), 1);
        chk("armed start frame", 32'(frame_idx), 0);
        step();

        // ---------------- non-looping run ----------------
        for (int k = 1; k <= 24; k++) begin
            pulse();
            chk($sformatf("seq[%0d] frame", k), 32'(frame_idx), (k / 4 > 5) ? 5 : k / 4);
            chk($sformatf("seq[%0d] busy", k),  32'(busy), (k == 24) ? 0 : 1);
            chk($sformatf("seq[%0d] done", k),  32'(done), (k == 24) ? 1 : 0);
            if (k < 24) begin
                step();
                chk($sformatf("seq[%0d] done low", k), 32'(done), 0);
                step();
            end
        end

        // trigger in the same cycle as done is kept and restarts next frame
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("hold done cleared", 32'(done), 0);
        chk("hold frame", 32'(frame_idx), 5);
        chk("hold busy", 32'(busy), 0);
        step();
        step();
        chk("hold frame still", 32'(frame_idx), 5);
        pulse();
        chk("restart busy", 32'(busy), 1);
        chk("restart frame", 32'(frame_idx), 0);
        step();

        // ---------------- looping run ----------------
        loop_en = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            pulse();
            chk($sformatf("loop[%0d] frame", k), 32'(frame_idx), (k / 4) % 6);
            chk($sformatf("loop[%0d] busy", k),  32'(busy), 1);
            chk($sformatf("loop[%0d] done", k),  32'(done), 0);
            step();
            step();
        end

        // ---------------- asynchronous abort at frame 3 ----------------
        chk("pre-abort frame", 32'(frame_idx), 3);
        reset_n = 1'b0;
        #2;
        chk("abort frame", 32'(frame_idx), 0);
        chk("abort busy", 32'(busy), 0);
        #2 reset_n = 1'b1;
        step();

        // ---------------- trigger coincident with frame_start ----------------
        loop_en     = 1'b0;
        trigger     = 1'b1;
        frame_start = 1'b1;
        step();
        trigger     = 1'b0;
        frame_start = 1'b0;
        chk("coincident start busy", 32'(busy), 1);
        chk("coincident start frame", 32'(frame_idx), 0);
        step();
        for (int k = 1; k <= 8; k++) begin
            pulse();
            step();
        end
        chk("addr setup frame", 32'(frame_idx), 2);

        // ---------------- pixel pipeline table (frame 2, base 6400) ----------
        //            fs   pos_x    pos_y    DrawX    DrawY    blk  rom_q  addr       pv    pi
        tv[0]  = '{1'b0, 10'd100, 10'd200, 10'd149, 10'd263, 1'b1, 3'd0, 15'd9599, 1'b0, 3'd0};
        tv[1]  = '{1'b0, 10'd100, 10'd200, 10'd150, 10'd263, 1'b1, 3'd0, 15'd0,    1'b0, 3'd0};
        tv[2]  = '{1'b0, 10'd100, 10'd200, 10'd100, 10'd200, 1'b0, 3'd5, 15'd6400, 1'b0, 3'd5};
        tv[3]  = '{1'b0, 10'd100, 10'd200, 10'd101, 10'd200, 1'b1, 3'd5, 15'd6401, 1'b0, 3'd5};
        tv[4]  = '{1'b0, 10'd100, 10'd200, 10'd99,  10'd200, 1'b1, 3'd5, 15'd0,    1'b1, 3'd5};
        tv[5]  = '{1'b0, 10'd100, 10'd200, 10'd120, 10'd199, 1'b1, 3'd3, 15'd0,    1'b0, 3'd3};
        tv[6]  = '{1'b0, 10'd100, 10'd200, 10'd120, 10'd264, 1'b1, 3'd3, 15'd0,    1'b0, 3'd3};
        tv[7]  = '{1'b0, 10'd100, 10'd200, 10'd125, 10'd210, 1'b1, 3'd7, 15'd6925, 1'b0, 3'd7};
        tv[8]  = '{1'b0, 10'd100, 10'd200, 10'd0,   10'd0,   1'b1, 3'd2, 15'd0,    1'b1, 3'd2};
        tv[9]  = '{1'b0, 10'd300, 10'd200, 10'd125, 10'd210, 1'b1, 3'd0, 15'd6925, 1'b0, 3'd0};
        tv[10] = '{1'b1, 10'd300, 10'd200, 10'd125, 10'd210, 1'b1, 3'd4, 15'd6925, 1'b1, 3'd4};
        tv[11] = '{1'b0, 10'd300, 10'd200, 10'd125, 10'd210, 1'b1, 3'd0, 15'd0,    1'b0, 3'd0};
        tv[12] = '{1'b0, 10'd300, 10'd200, 10'd310, 10'd210, 1'b1, 3'd0, 15'd6910, 1'b0, 3'd0};

        for (int i = 0; i < 13; i++) begin
            frame_start = tv[i].fs;
            pos_x       = tv[i].px;
            pos_y       = tv[i].py;
            DrawX       = tv[i].dx;
            DrawY       = tv[i].dy;
            blank       = tv[i].blk;
            rom_q       = tv[i].q;
            step();
            chk($sformatf("pix[%0d] rom_address", i), 32'(rom_address), 32'(tv[i].e_addr));
            chk($sformatf("pix[%0d] pixel_valid", i), 32'(pixel_valid), 32'(tv[i].e_pv));
            chk($sformatf("pix[%0d] pixel_index", i), 32'(pixel_index), 32'(tv[i].e_pi));
            chk($sformatf("pix[%0d] frame_idx", i),   32'(frame_idx),   2);
            chk($sformatf("pix[%0d] busy", i),        32'(busy),        1);
        end
        frame_start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
